// File: rtl/miss_arbiter.sv
// Round-robin arbiter placing I-cache and D-cache miss/writeback requests onto the
// shared L2 request port, with saturating grant and contention statistics.
module miss_arbiter #(
   parameter int ADDR_W = 26,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   // instruction cache side
   input  logic              i_req_valid,
   input  logic [ADDR_W-1:0] i_req_addr,
   output logic              i_req_ready,
   output logic              i_done,
   // data cache side
   input  logic              d_req_valid,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic              d_req_write,
   output logic              d_req_ready,
   output logic              d_done,
   // L2 request port
   output logic              l2_req_valid,
   output logic [ADDR_W-1:0] l2_req_addr,
   output logic              l2_req_write,
   output logic              l2_req_src,
   input  logic              l2_req_ready,
   input  logic              l2_done,
   // statistics
   output logic [CNT_W-1:0]  i_grants,
   output logic [CNT_W-1:0]  d_grants,
   output logic [CNT_W-1:0]  contention
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   localparam logic SRC_I = 1'b0;
   localparam logic SRC_D = 1'b1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              write_q, write_d;
   logic              src_q, src_d;
   logic              i_done_q, i_done_d;
   logic              d_done_q, d_done_d;
   logic [CNT_W-1:0]  i_grants_q, i_grants_d;
   logic [CNT_W-1:0]  d_grants_q, d_grants_d;
   logic [CNT_W-1:0]  contention_q, contention_d;

   logic              both_valid;
   logic              grant_i;
   logic              grant_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   // On a tie the source that did not complete the previous transaction wins.
   assign both_valid = i_req_valid && d_req_valid;
   assign grant_i    = i_req_valid && (!d_req_valid || (last_grant_q == SRC_D));
   assign grant_d    = d_req_valid && (!i_req_valid || (last_grant_q == SRC_I));

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      write_d      = write_q;
      src_d        = src_q;
      i_done_d     = 1'b0;
      d_done_d     = 1'b0;
      i_grants_d   = i_grants_q;
      d_grants_d   = d_grants_q;
      contention_d = contention_q;
      i_req_ready  = 1'b0;
      d_req_ready  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            i_req_ready = grant_i;
            d_req_ready = grant_d;
            if (both_valid) begin
               contention_d = sat_inc(contention_q);
            end
            if (grant_i) begin
               addr_d     = i_req_addr;
               write_d    = 1'b0;
               src_d      = SRC_I;
               i_grants_d = sat_inc(i_grants_q);
               state_d    = ST_ISSUE;
            end else if (grant_d) begin
               addr_d     = d_req_addr;
               write_d    = d_req_write;
               src_d      = SRC_D;
               d_grants_d = sat_inc(d_grants_q);
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (l2_req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (l2_done) begin
               i_done_d     = (src_q == SRC_I);
               d_done_d     = (src_q == SRC_D);
               last_grant_d = src_q;
               state_d      = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= SRC_D;
         addr_q       <= '0;
         write_q      <= 1'b0;
         src_q        <= SRC_I;
         i_done_q     <= 1'b0;
         d_done_q     <= 1'b0;
         i_grants_q   <= '0;
         d_grants_q   <= '0;
         contention_q <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         write_q      <= write_d;
         src_q        <= src_d;
         i_done_q     <= i_done_d;
         d_done_q     <= d_done_d;
         i_grants_q   <= i_grants_d;
         d_grants_q   <= d_grants_d;
         contention_q <= contention_d;
      end
   end

   // Latched fields are only meaningful while l2_req_valid is high.
   assign l2_req_valid = (state_q == ST_ISSUE);
   assign l2_req_addr  = addr_q;
   assign l2_req_write = write_q;
   assign l2_req_src   = src_q;
   assign i_done       = i_done_q;
   assign d_done       = d_done_q;
   assign i_grants     = i_grants_q;
   assign d_grants     = d_grants_q;
   assign contention   = contention_q;

endmodule

// File: tb/tb_miss_arbiter.sv
// Scoreboard bench for miss_arbiter: a stimulus process pushes predicted L2 requests,
// a separate L2 responder/monitor pops and checks them and the done pulses.
module tb_miss_arbiter;

   typedef struct packed {
      logic        src;
      logic [25:0] addr;
      logic        wr;
   } req_t;

   logic        clk;
   logic        rst;
   logic        i_req_valid, d_req_valid, d_req_write;
   logic [25:0] i_req_addr, d_req_addr;
   logic        l2_req_ready, l2_done;

   logic        i_req_ready, d_req_ready, i_done, d_done;
   logic        l2_req_valid, l2_req_write, l2_req_src;
   logic [25:0] l2_req_addr;
   logic [31:0] i_grants, d_grants, contention;

   logic        s_i_req_ready, s_d_req_ready, s_i_done, s_d_done;
   logic        s_l2_req_valid, s_l2_req_write, s_l2_req_src;
   logic [25:0] s_l2_req_addr;
   logic [3:0]  s_i_grants, s_d_grants, s_contention;

   int     n_checks = 0;
   int     n_errors = 0;
   req_t   exp_req_q[$];
   req_t   cur;
   int     rsp_phase = 0;
   int     hold_cnt = 0;
   int     done_cnt = 0;
   int     due = -1;
   int     cfg_rdy_dly = 0;
   int     cfg_done_dly = 0;
   bit     cfg_hold_done = 0;
   bit     force_done = 0;
   longint mdl_ig = 0, mdl_dg = 0, mdl_ct = 0;
   logic   mdl_last = 1'b1;

   miss_arbiter dut (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready), .i_done(i_done),
      .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_write(d_req_write),
      .d_req_ready(d_req_ready), .d_done(d_done),
      .l2_req_valid(l2_req_valid), .l2_req_addr(l2_req_addr), .l2_req_write(l2_req_write),
      .l2_req_src(l2_req_src), .l2_req_ready(l2_req_ready), .l2_done(l2_done),
      .i_grants(i_grants), .d_grants(d_grants), .contention(contention)
   );

   // Narrow-counter copy sharing all inputs, used to observe saturation.
   miss_arbiter #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(s_i_req_ready), .i_done(s_i_done),
      .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_write(d_req_write),
      .d_req_ready(s_d_req_ready), .d_done(s_d_done),
      .l2_req_valid(s_l2_req_valid), .l2_req_addr(s_l2_req_addr), .l2_req_write(s_l2_req_write),
      .l2_req_src(s_l2_req_src), .l2_req_ready(l2_req_ready), .l2_done(l2_done),
      .i_grants(s_i_grants), .d_grants(s_d_grants), .contention(s_contention)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic longint satv(input longint v, input longint m);
      return (v > m) ? m : v;
   endfunction

   task automatic check_counters();
      check("i_grants", i_grants, satv(mdl_ig, 64'hFFFF_FFFF));
      check("d_grants", d_grants, satv(mdl_dg, 64'hFFFF_FFFF));
      check("contention", contention, satv(mdl_ct, 64'hFFFF_FFFF));
      check("sat_i_grants", s_i_grants, satv(mdl_ig, 15));
      check("sat_d_grants", s_d_grants, satv(mdl_dg, 15));
      check("sat_contention", s_contention, satv(mdl_ct, 15));
   endtask

   task automatic check_reset_outputs();
      check("rst_readies", {i_req_ready, d_req_ready, i_done, d_done}, 0);
      check("rst_l2", {l2_req_valid, l2_req_addr, l2_req_write, l2_req_src}, 0);
      check("rst_counters", {i_grants, d_grants}, 0);
      check("rst_contention", contention, 0);
      check("rst_sat_ctl", {s_i_req_ready, s_d_req_ready, s_i_done, s_d_done, s_l2_req_valid,
                            s_l2_req_addr, s_l2_req_write, s_l2_req_src}, 0);
      check("rst_sat_counters", {s_i_grants, s_d_grants, s_contention}, 0);
   endtask

   // One transaction from the requester side; the winner is predicted from round-robin rules.
   task automatic do_txn(input logic iv, input logic [25:0] ia, input logic dv,
                         input logic [25:0] da, input logic dw, input bit chg, input bit hold_loser);
      bit   got;
      logic pick_d;
      req_t r;
      @(negedge clk);
      i_req_valid = iv; i_req_addr = ia;
      d_req_valid = dv; d_req_addr = da; d_req_write = dw;
      #1;
      got = 0;
      for (int k = 0; k < 100; k++) begin
         if (i_req_ready || d_req_ready) begin
            got = 1;
            break;
         end
         @(negedge clk);
         if (chg) begin
            if (iv) i_req_addr = 26'($urandom);
            if (dv) d_req_addr = 26'($urandom);
         end
         #1;
      end
      if (!got) begin
         check("accept_timeout", 0, 1);
         i_req_valid = 0; d_req_valid = 0;
         return;
      end
      pick_d = dv && (!iv || (mdl_last == 1'b0));
      check("i_req_ready", i_req_ready, !pick_d);
      check("d_req_ready", d_req_ready, pick_d);
      r.src  = pick_d;
      r.addr = pick_d ? d_req_addr : i_req_addr;
      r.wr   = pick_d & dw;
      if (iv && dv) mdl_ct++;
      if (pick_d) mdl_dg++; else mdl_ig++;
      mdl_last = pick_d;
      $display("txn %0d: src=%0d addr=%07h write=%0d", n_checks, r.src, r.addr, r.wr);
      @(posedge clk);
      #1;
      exp_req_q.push_back(r);
      if (pick_d || !hold_loser) d_req_valid = 0;
      if (!pick_d || !hold_loser) i_req_valid = 0;
      @(negedge clk);
      #1;
      check("accept_to_l2_valid", l2_req_valid, 1);
      check("busy_readies", {i_req_ready, d_req_ready}, 0);
      check_counters();
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int k = 0; k < 300; k++) begin
         if (rsp_phase == 0 && exp_req_q.size() == 0 && due < 0 && !l2_req_valid) begin
            ok = 1;
            break;
         end
         @(negedge clk);
         #1;
      end
      if (!ok) check("idle_timeout", 0, 1);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #2;
      rst = 1;
      #1;
      check_reset_outputs();
      exp_req_q.delete();
      mdl_ig = 0; mdl_dg = 0; mdl_ct = 0; mdl_last = 1'b1;
      @(posedge clk);
      #2;
      rst = 0;
   endtask

   // L2 model and output monitor.
   initial begin
      l2_req_ready = 0;
      l2_done = 0;
      forever begin
         @(negedge clk);
         l2_req_ready = 0;
         l2_done = 0;
         if (due >= 0 || i_done || d_done) begin
            check("i_done", i_done, due == 0);
            check("d_done", d_done, due == 1);
         end
         due = -1;
         if (rst) begin
            rsp_phase = 0;
            force_done = 0;
            continue;
         end
         if (force_done) begin
            l2_done = 1;
            force_done = 0;
         end
         if (rsp_phase == 0 && l2_req_valid) begin
            if (exp_req_q.size() == 0) begin
               check("unexpected_l2_req", 1, 0);
               cur = '0;
            end else begin
               cur = exp_req_q.pop_front();
            end
            check("l2_addr", l2_req_addr, cur.addr);
            check("l2_src", l2_req_src, cur.src);
            check("l2_write", l2_req_write, cur.wr);
            hold_cnt = cfg_rdy_dly;
            rsp_phase = 1;
         end else if (rsp_phase == 1) begin
            check("issue_hold", {l2_req_valid, l2_req_addr, l2_req_src, l2_req_write},
                  {1'b1, cur.addr, cur.src, cur.wr});
            check("issue_readies", {i_req_ready, d_req_ready}, 0);
         end else if (rsp_phase == 2) begin
            check("wait_valid_low", l2_req_valid, 0);
            if (!cfg_hold_done) begin
               if (done_cnt == 0) begin
                  l2_done = 1;
                  due = cur.src;
                  rsp_phase = 0;
               end else begin
                  done_cnt--;
               end
            end
         end
         if (rsp_phase == 1) begin
            if (hold_cnt == 0) begin
               l2_req_ready = 1;
               rsp_phase = 2;
               done_cnt = cfg_done_dly;
            end else begin
               hold_cnt--;
            end
         end
      end
   end

   initial begin
      logic       iv, dv, dw;
      rst = 1;
      i_req_valid = 0; i_req_addr = '0;
      d_req_valid = 0; d_req_addr = '0; d_req_write = 0;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      @(posedge clk);
      #2;
      rst = 0;

      // single I-side fill, L2 immediately ready, done one cycle later
      cfg_rdy_dly = 0; cfg_done_dly = 0;
      do_txn(1, 26'h0001234, 0, 26'h0, 0, 0, 0);
      wait_idle();

      // both held valid from reset: strict alternation starting with I
      apply_reset();
      for (int t = 0; t < 4; t++) begin
         do_txn(1, 26'h0000010, 1, 26'h0000020, 1, 0, t != 3);
      end
      wait_idle();
      check("t2_i_grants", i_grants, 2);
      check("t2_d_grants", d_grants, 2);
      check("t2_contention", contention, 4);

      // L2 back-pressure for 5 cycles with the loser still requesting
      cfg_rdy_dly = 5; cfg_done_dly = 2;
      do_txn(1, 26'h0ABCDEF, 1, 26'h1234567, 1, 0, 1);
      do_txn(0, 26'h0, 1, 26'h1234567, 1, 0, 0);
      wait_idle();

      // spurious l2_done in IDLE, then in ISSUE
      @(posedge clk);
      #2;
      force_done = 1;
      repeat (3) @(negedge clk);
      #1;
      check("spurious_idle_l2_valid", l2_req_valid, 0);
      cfg_rdy_dly = 4; cfg_done_dly = 1;
      do_txn(0, 26'h0, 1, 26'h3FFFFFF, 0, 0, 0);
      @(posedge clk);
      #2;
      force_done = 1;
      wait_idle();

      // reset while waiting for L2 completion, then a late l2_done
      cfg_rdy_dly = 0; cfg_done_dly = 0; cfg_hold_done = 1;
      do_txn(0, 26'h0, 1, 26'h0000555, 1, 0, 0);
      repeat (3) @(negedge clk);
      apply_reset();
      cfg_hold_done = 0;
      force_done = 1;
      repeat (3) @(negedge clk);
      do_txn(1, 26'h0000AAA, 1, 26'h0000BBB, 0, 0, 0);
      wait_idle();

      // 20 I-side transactions to saturate the narrow counters
      for (int t = 0; t < 20; t++) begin
         do_txn(1, 26'($urandom), 0, 26'h0, 0, 0, 0);
      end
      wait_idle();
      check("sat_i_grants_max", s_i_grants, 4'hF);

      // randomized traffic
      for (int t = 0; t < 60; t++) begin
         iv = 1'($urandom);
         dv = 1'($urandom);
         dw = 1'($urandom);
         if (!iv && !dv) iv = 1;
         cfg_rdy_dly = $urandom_range(0, 3);
         cfg_done_dly = $urandom_range(0, 3);
         do_txn(iv, 26'($urandom), dv, 26'($urandom), dw, 1'($urandom), 0);
         if (cfg_rdy_dly >= 1 && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #2;
            force_done = 1;
         end
      end
      wait_idle();
      check("final_queue_empty", exp_req_q.size(), 0);
      check_counters();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
